// File: rtl/frontend_irq_ctrl_pkg.sv
// Shared frontend types: instruction address, control pulses and the
// interrupt controller state encoding.
package Frontend;

  localparam int IADDR_W = 16;

  typedef logic [IADDR_W-1:0] Iaddr;

  typedef struct packed {
    logic wakeup;
    logic interrupt;
  } Frontend_control;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ARM     = 2'd1,
    FIRE    = 2'd2,
    HANDLER = 2'd3
  } Irq_state;

endpackage

// File: rtl/frontend_irq_ctrl_priority.sv
// Combinational lowest-index-wins encoder over the pending interrupt lines.
module irq_priority_encoder #(
  parameter int N_IRQ = 8,
  parameter int IDW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] i_req,
  output logic             o_valid,
  output logic [IDW-1:0]   o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDW'(i);
    end
  end

endmodule

// File: rtl/frontend_irq_ctrl.sv
// Interrupt/wakeup controller for the single-thread frontend: edge-detects
// irq lines, gates the processor clock and issues wakeup/interrupt/jump pulses.
//
//   state   | meaning
//   RUN     | idle, waiting for a pending request
//   ARM     | frontend asleep: clock forced on for one cycle before firing
//   FIRE    | one-cycle interrupt/jump pulse (wakeup if entered from ARM)
//   HANDLER | handler running, waiting for irq_return
module frontend_irq_ctrl
  import Frontend::*;
#(
  parameter int N_IRQ      = 8,
  parameter int VEC_BASE   = 0,
  parameter int VEC_STRIDE = 16,
  localparam int IDW       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sleeping,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_en,
  input  logic            irq_return,
  output Frontend_control ctrl,
  output logic            jump,
  output Iaddr            jump_vec,
  output logic            clk_gate,
  output logic            irq_active,
  output logic [IDW-1:0]  irq_id
);

  Irq_state         r_state;
  Frontend_control  r_ctrl;
  logic             r_jump;
  Iaddr             r_jump_vec;
  logic             r_irq_active;
  logic [IDW-1:0]   r_irq_id;
  logic [N_IRQ-1:0] r_irq_q;
  logic [N_IRQ-1:0] r_pending;

  logic             w_valid;
  logic [IDW-1:0]   w_idx;
  logic [N_IRQ-1:0] w_set;
  logic [N_IRQ-1:0] w_clr;
  Iaddr             w_vec;

  irq_priority_encoder #(
    .N_IRQ (N_IRQ),
    .IDW   (IDW)
  ) u_prio (
    .i_req   (r_pending),
    .o_valid (w_valid),
    .o_idx   (w_idx)
  );

  assign w_set = irq & ~r_irq_q & irq_en;
  // Set beats clear so an edge landing in the FIRE cycle re-fires later.
  assign w_clr = (r_state == FIRE) ? (N_IRQ'(1) << r_irq_id) : '0;
  assign w_vec = Iaddr'(VEC_BASE + VEC_STRIDE * int'(w_idx));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_ctrl       <= '0;
      r_jump       <= 1'b0;
      r_jump_vec   <= '0;
      r_irq_active <= 1'b0;
      r_irq_id     <= '0;
      r_irq_q      <= '0;
      r_pending    <= '0;
    end else begin
      r_irq_q    <= irq;
      r_pending  <= (r_pending & ~w_clr) | w_set;
      r_ctrl     <= '0;
      r_jump     <= 1'b0;
      r_jump_vec <= '0;
      unique case (r_state)
        RUN: begin
          if (w_valid) begin
            if (sleeping) begin
              r_state <= ARM;
            end else begin
              r_state          <= FIRE;
              r_ctrl.interrupt <= 1'b1;
              r_jump           <= 1'b1;
              r_jump_vec       <= w_vec;
              r_irq_id         <= w_idx;
            end
          end
        end
        ARM: begin
          r_state          <= FIRE;
          r_ctrl.wakeup    <= 1'b1;
          r_ctrl.interrupt <= 1'b1;
          r_jump           <= 1'b1;
          r_jump_vec       <= w_vec;
          r_irq_id         <= w_idx;
        end
        FIRE: begin
          r_state      <= HANDLER;
          r_irq_active <= 1'b1;
        end
        HANDLER: begin
          if (irq_return) begin
            r_state      <= RUN;
            r_irq_active <= 1'b0;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign ctrl       = r_ctrl;
  assign jump       = r_jump;
  assign jump_vec   = r_jump_vec;
  assign irq_active = r_irq_active;
  assign irq_id     = r_irq_id;
  assign clk_gate   = reset | ~sleeping | (r_state == ARM) | (r_state == FIRE);

endmodule

// File: tb/tb_frontend_irq_ctrl.sv
// Directed bench for frontend_irq_ctrl with hand-computed expectations.
module tb_frontend_irq_ctrl;
  import Frontend::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            sleeping;
  logic [7:0]      irq;
  logic [7:0]      irq_en;
  logic            irq_return;
  Frontend_control ctrl;
  logic            jump;
  Iaddr            jump_vec;
  logic            clk_gate;
  logic            irq_active;
  logic [2:0]      irq_id;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  frontend_irq_ctrl #(.N_IRQ(8), .VEC_BASE(0), .VEC_STRIDE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .sleeping   (sleeping),
    .irq        (irq),
    .irq_en     (irq_en),
    .irq_return (irq_return),
    .ctrl       (ctrl),
    .jump       (jump),
    .jump_vec   (jump_vec),
    .clk_gate   (clk_gate),
    .irq_active (irq_active),
    .irq_id     (irq_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks every pulse output at once: {wakeup, interrupt, jump}, vector.
  task automatic chk_pulse(input string tag, input logic [2:0] exp_p, input logic [15:0] exp_vec);
    chk({tag, "_pulses"}, {29'd0, ctrl.wakeup, ctrl.interrupt, jump}, {29'd0, exp_p});
    chk({tag, "_vec"}, {16'd0, jump_vec}, {16'd0, exp_vec});
  endtask

  task automatic do_return();
    irq_return = 1'b1;
    tick();
    irq_return = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sleeping = 1'b0; irq = '0; irq_en = '1; irq_return = 1'b0;
    tick(); tick();
    chk_pulse("reset", 3'b000, 16'h0);
    chk("reset_gate", clk_gate, 1);
    chk("reset_active", irq_active, 0);
    chk("reset_id", irq_id, 0);
    reset = 1'b0;
    tick();

    // 1: running path, line 3
    irq = 8'h08;
    tick();
    chk_pulse("t1_decide", 3'b000, 16'h0);
    tick();
    chk_pulse("t1_fire", 3'b011, 16'h30);
    chk("t1_id", irq_id, 3);
    tick();
    chk_pulse("t1_handler", 3'b000, 16'h0);
    chk("t1_active", irq_active, 1);
    tick();
    chk("t1_active_hold", irq_active, 1);
    do_return();
    chk("t1_return", irq_active, 0);
    irq = '0;
    tick();

    // 2: sleeping path, line 0
    sleeping = 1'b1;
    tick();
    chk("t2_gated", clk_gate, 0);
    irq = 8'h01;
    tick();
    chk("t2_gate_run", clk_gate, 0);
    tick();
    chk("t2_arm_gate", clk_gate, 1);
    chk_pulse("t2_arm", 3'b000, 16'h0);
    tick();
    chk_pulse("t2_fire", 3'b111, 16'h0);
    chk("t2_fire_gate", clk_gate, 1);
    tick();
    chk("t2_handler_gate", clk_gate, 0);
    chk("t2_active", irq_active, 1);
    sleeping = 1'b0;
    #1;
    chk("t2_gate_follow", clk_gate, 1);
    do_return();
    irq = '0;
    tick();

    // 3: two lines together, lowest first, second only after return
    irq = 8'h22;
    tick(); tick();
    chk_pulse("t3_fire1", 3'b011, 16'h10);
    chk("t3_id1", irq_id, 1);
    tick(); tick();
    chk_pulse("t3_held", 3'b000, 16'h0);
    do_return();
    chk_pulse("t3_run", 3'b000, 16'h0);
    tick();
    chk_pulse("t3_fire2", 3'b011, 16'h50);
    chk("t3_id2", irq_id, 5);
    tick();
    do_return();
    irq = '0;
    tick();

    // 4: disabled edge, then enabled steady level: never fires
    irq_en = 8'hFB;
    irq = 8'h04;
    tick(); tick();
    chk("t4_dis", jump, 0);
    irq_en = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_level", jump, 0);
    end
    irq = '0;
    tick();

    // 4b: edge arriving on the line being cleared in FIRE re-fires
    irq = 8'h04;
    tick();
    irq = 8'h00;
    tick();
    chk_pulse("t4b_fire1", 3'b011, 16'h20);
    irq = 8'h04;
    tick();
    do_return();
    tick();
    chk_pulse("t4b_fire2", 3'b011, 16'h20);
    tick();
    do_return();
    irq = '0;
    tick();

    // 5: reset during ARM
    sleeping = 1'b1;
    irq = 8'h40;
    tick(); tick();
    chk("t5_arm_gate", clk_gate, 1);
    reset = 1'b1;
    irq = '0;
    tick();
    chk_pulse("t5_reset", 3'b000, 16'h0);
    chk("t5_reset_gate", clk_gate, 1);
    chk("t5_reset_active", irq_active, 0);
    chk("t5_reset_id", irq_id, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_fire", {ctrl.interrupt, jump, clk_gate}, 0);
    end
    sleeping = 1'b0;
    tick();

    // 6: irq_return coinciding with a new edge on line 4
    irq = 8'h01;
    tick(); tick();
    chk_pulse("t6_fire0", 3'b011, 16'h0);
    tick();
    irq = 8'h11;
    do_return();
    chk("t6_run", {irq_active, jump}, 0);
    tick();
    chk_pulse("t6_fire4", 3'b011, 16'h40);
    chk("t6_id", irq_id, 4);
    tick();
    chk("t6_active", irq_active, 1);
    do_return();
    irq = '0;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/frontend_irq_ctrl.md
# frontend_irq_ctrl

Interrupt and wakeup controller that drives the control side of the single-thread frontend. It watches the frontend's `sleeping` output and external interrupt lines, gates the processor clock, and emits the wakeup, interrupt and jump pulses that the frontend consumes through `Frontend_control` and the jump fields of `Branch_control`. It runs on the ungated clock. The integrating top ORs `jump`/`jump_vec` into `Branch_control` alongside the branch unit.

## Interface
Parameters:
- N_IRQ, 8, number of interrupt lines (1..32)
- VEC_BASE, 0, jump target of line 0 (Iaddr units)
- VEC_STRIDE, 16, vector spacing per line (Iaddr units)

Ports:
- clk  in  1  ungated system clock
- reset  in  1  synchronous, active-high
- sleeping  in  1  frontend is asleep
- irq  in  N_IRQ  interrupt requests, rising-edge sensitive
- irq_en  in  N_IRQ  per-line enable
- irq_return  in  1  one-cycle pulse, handler finished
- ctrl  out  Frontend_control  .wakeup, .interrupt pulses
- jump  out  1  jump request to frontend
- jump_vec  out  $bits(Iaddr)  jump target
- clk_gate  out  1  processor clock enable (proc_clk = clk & clk_gate)
- irq_active  out  1  handler in progress
- irq_id  out  $clog2(N_IRQ)  id of last taken line

The block uses one clock. Reset is synchronous and active-high.

## Operation
- Edge detect: `irq_q` holds the previous `irq`. `pending[i]` is set when `irq[i] & ~irq_q[i] & irq_en[i]`. A disabled line or a steady level sets nothing. Pending bits are sticky until taken.
- Priority: the lowest pending index wins.
- FSM states:
  - RUN
    - Any pending and !sleeping -> FIRE.
    - Any pending and sleeping -> ARM.
  - ARM
    - clk_gate forced to 1.
    - Always -> FIRE, with the wake flag set.
  - FIRE
    - Single cycle.
    - interrupt=1 and jump=1.
    - wakeup=1 only if entered from ARM.
    - jump_vec = VEC_BASE + id*VEC_STRIDE, computed modulo 2^$bits(Iaddr).
    - pending[id] cleared; irq_id := id.
    - -> HANDLER.
  - HANDLER
    - irq_active=1.
    - New edges accumulate but are not taken.
    - irq_return -> RUN.
- clk_gate = reset | ~sleeping | (state in {ARM, FIRE}). This is combinational on `sleeping`.
- Outside FIRE, jump_vec=0 and all pulses are 0.
- Simultaneous events:
  - Edge on a line in the same cycle it is cleared in FIRE: set wins, so the line re-fires later.
  - irq_return together with a pending request: go to RUN, then fire on the following decision.
  - irq_return outside HANDLER: ignored.
  - `sleeping` rising while in HANDLER: the clock gates off. The controller waits; irq_return cannot arrive until an external wake path exists. This is intended.
- Reset, including mid-ARM or mid-FIRE:
  - State RUN; pending, irq_q and irq_id cleared.
  - All pulses 0, irq_active 0.
  - clk_gate 1, so the frontend sees its reset.

## Timing
- Running path: edge sampled at posedge t sets pending. The FSM is in FIRE from t+1, so the pulses are high for exactly the cycle t+1..t+2.
- Sleeping path: one extra cycle. clk_gate rises in cycle t+1..t+2 (ARM); pulses occur in t+2..t+3.
- clk_gate returns to ~sleeping after FIRE. The frontend deasserts `sleeping` in response to wakeup.
- Back-to-back: the minimum spacing between two FIRE cycles is 3 cycles (FIRE, HANDLER with irq_return, RUN->FIRE decision).
- All outputs except clk_gate are registered state decodes.

## Structure
- Add `Irq_state` enum (RUN, ARM, FIRE, HANDLER) to package `Frontend`. `Frontend_control` and `Iaddr` are already there.
- Sub-module `irq_priority_encoder`:
  - Parameterised by N_IRQ.
  - Outputs valid and lowest-set index.
  - Purely combinational.

## Test plan
1. Running, irq_en='1, irq[3] rises -> one-cycle interrupt=1, jump=1, jump_vec=0x30, wakeup=0 two cycles after the edge; irq_active=1 until irq_return.
2. sleeping=1, clk_gate=0, irq[0] rises -> clk_gate=1 one cycle, then wakeup=interrupt=jump=1 with jump_vec=0x0; clk_gate follows ~sleeping afterwards.
3. irq[1] and irq[5] rise together -> first FIRE has irq_id=1, vec=0x10; second FIRE has vec=0x50, only after irq_return.
4. irq_en[2]=0 and irq[2] rises; later irq_en[2]=1 with irq[2] held high -> no FIRE ever.
5. reset asserted during ARM -> next cycle all pulses 0, clk_gate=1, pending=0; no FIRE after reset release.
6. irq_return in the same cycle as an irq[4] edge -> RUN, then FIRE with vec=0x40 on the next decision; no lost request.
